dwc_req0: RTL
=============

// Module: dwc_req0
// PURPOSE
//  Request-path data width converter (upsizer), the counterpart of the response-path downsizer.
//  - Packs narrow write words from the initiator (ID) side into one wide word for the request FIFO.
//  - The first accepted word fills the least-significant lane.
//  - A partial group is flushed early on id_req_last; unfilled lanes carry zero data and zero strobe.
// PARAMETERS
//  INPUT_DATA_WIDTH   32   width of one ID-side request word (multiple of 8)
//  OUTPUT_DATA_WIDTH  128  width of one FIFO-side request word (multiple of INPUT_DATA_WIDTH)
//  REQ_WORD_NUMBER    4    lanes per output word = OUTPUT_DATA_WIDTH/INPUT_DATA_WIDTH (>=2)
// PORTS
//  clk             in   1                    clock; all logic on rising edge
//  rst             in   1                    synchronous reset, active-high
//  id_req_valid    in   1                    ID word valid
//  id_req_ready    out  1                    block accepts ID word this cycle
//  id_req_wdata    in   INPUT_DATA_WIDTH     ID write data
//  id_req_wstrb    in   INPUT_DATA_WIDTH/8   ID byte strobes
//  id_req_last     in   1                    word closes the current group (early flush)
//  fifo_req_valid  out  1                    packed word valid
//  fifo_req_ready  in   1                    request FIFO accepts packed word
//  fifo_req_wdata  out  OUTPUT_DATA_WIDTH    packed data; lane k = bits [k*IW +: IW]
//  fifo_req_wstrb  out  OUTPUT_DATA_WIDTH/8  packed strobes; lane k = bits [k*IW/8 +: IW/8]
// BEHAVIOUR
//  Reset and handshakes
//  - Reset (rst=1 at clk edge): state=FILL, lane_cnt=0.
//    fifo_req_valid=0, fifo_req_wdata=0, fifo_req_wstrb=0. id_req_ready=0 while rst=1.
//  - Handshakes: ID word transfers when id_req_valid & id_req_ready.
//    Packed word transfers when fifo_req_valid & fifo_req_ready.
//  - fifo_req_* are registered outputs. id_req_ready is combinational from state and fifo_req_ready only.
//  - State machine: FILL (collecting) and SEND (packed word presented).
//  FILL
//  - id_req_ready=1, fifo_req_valid=0.
//  - On an ID transfer: lane[lane_cnt] takes wdata and wstrb.
//  - If lane_cnt==REQ_WORD_NUMBER-1 or id_req_last=1: go to SEND, fifo_req_valid=1 next cycle, lane_cnt=0.
//  - Otherwise lane_cnt+1.
//  SEND
//  - fifo_req_valid=1. wdata and wstrb hold stable until the FIFO transfer.
//  - id_req_ready = fifo_req_ready.
//  - FIFO transfer without ID transfer: buffer and strobes cleared to 0, go to FILL, lane_cnt=0.
//  - FIFO transfer with simultaneous ID transfer:
//    - new word goes into lane 0 and other lanes clear.
//    - If id_req_last=1: stay in SEND (valid stays 1, single-lane word).
//    - Else: go to FILL with lane_cnt=1.
//    - Sustains 1 ID word/cycle with no bubble.
//  - No FIFO transfer: no ID word is accepted, no state change.
//  Timing and boundary cases
//  - Latency: group-closing ID word accepted at edge t -> fifo_req_valid=1 from t+1.
//  - id_req_last with lane_cnt==REQ_WORD_NUMBER-1 behaves as a normal full group (one flush, not two).
//  - A word with wstrb=0 still occupies its lane. Strobes are never synthesised; they are copied per lane.
//  - id_req_last on the first word of a group: lane 0 only, upper lanes data=0, strb=0.
//  - fifo_req_ready while fifo_req_valid=0 is ignored.
//  - id_req_* is ignored while id_req_ready=0 (no sampling, no state change).
//  - Reset mid-group or in SEND discards all buffered lanes; no packed word is emitted.
// TESTING
//  1. Full pack: 4 words AAAAAAAA,BBBBBBBB,CCCCCCCC,DDDDDDDD with wstrb=F, fifo_req_ready=1
//     -> one beat wdata=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, wstrb=16'hFFFF, 1 cycle after 4th word.
//  2. Early flush: 11111111, then 22222222 with last=1
//     -> wdata=128'h0_0_22222222_11111111, wstrb=16'h00FF; next group restarts at lane 0.
//  3. Backpressure: full group with fifo_req_ready=0 for 5 cycles
//     -> valid/wdata stable, id_req_ready=0, 5th ID word not accepted until FIFO transfer.
//  4. Back-to-back: 8 words streamed with both readies=1
//     -> two packed beats with no bubble on ID side, correct lane order in each.
//  5. Strobes: words with wstrb 1,0,8,F
//     -> fifo_req_wstrb=16'hF801, data lanes copied unchanged.
//  6. Reset mid-op: 2 words accepted, rst=1 for 1 cycle, then 4 new words
//     -> exactly one packed beat containing only the 4 new words; outputs 0 during reset.

Source files
------------

// File: rtl/dwc_req0.sv
// Request-path upsizer: packs narrow ID-side write words (data + strobes) into one
// wide request-FIFO word, lane 0 first, with early flush on id_req_last.
module dwc_req0 #(
    parameter int INPUT_DATA_WIDTH  = 32,
    parameter int OUTPUT_DATA_WIDTH = 128,
    parameter int REQ_WORD_NUMBER   = OUTPUT_DATA_WIDTH / INPUT_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_req_valid,
    output logic                           id_req_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]    id_req_wdata,
    input  logic [INPUT_DATA_WIDTH/8-1:0]  id_req_wstrb,
    input  logic                           id_req_last,
    output logic                           fifo_req_valid,
    input  logic                           fifo_req_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0]   fifo_req_wdata,
    output logic [OUTPUT_DATA_WIDTH/8-1:0] fifo_req_wstrb
);

    localparam int IW  = INPUT_DATA_WIDTH;
    localparam int IS  = INPUT_DATA_WIDTH / 8;
    localparam int OW  = OUTPUT_DATA_WIDTH;
    localparam int OS  = OUTPUT_DATA_WIDTH / 8;
    localparam int LCW = (REQ_WORD_NUMBER > 2) ? $clog2(REQ_WORD_NUMBER) : 1;
    localparam logic [LCW-1:0] LAST_LANE = LCW'(REQ_WORD_NUMBER - 1);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [LCW-1:0] lane_cnt;
    logic [LCW-1:0] lane_cnt_n;
    logic [OW-1:0]  data_q;
    logic [OW-1:0]  data_n;
    logic [OS-1:0]  strb_q;
    logic [OS-1:0]  strb_n;
    logic           id_fire;
    logic           fifo_fire;

    // Handshakes: a word moves on a side only in a cycle where valid and ready are both high.
    // In SEND the ID side is only opened when the packed word leaves in the same cycle.
    assign id_req_ready   = !rst && ((state == FILL) || fifo_req_ready);
    assign fifo_req_valid = (state == SEND);
    assign fifo_req_wdata = data_q;
    assign fifo_req_wstrb = strb_q;
    assign id_fire        = id_req_valid && id_req_ready;
    assign fifo_fire      = fifo_req_valid && fifo_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            lane_cnt <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            state    <= state_n;
            lane_cnt <= lane_cnt_n;
            data_q   <= data_n;
            strb_q   <= strb_n;
        end
    end

    always_comb begin
        state_n    = state;
        lane_cnt_n = lane_cnt;
        data_n     = data_q;
        strb_n     = strb_q;
        unique case (state)
            FILL: begin
                if (id_fire) begin
                    for (int k = 0; k < REQ_WORD_NUMBER; k++) begin
                        if (lane_cnt == LCW'(k)) begin
                            data_n[k*IW +: IW] = id_req_wdata;
                            strb_n[k*IS +: IS] = id_req_wstrb;
                        end
                    end
                    // A last flag on the final lane is just a full group: one flush.
                    if ((lane_cnt == LAST_LANE) || id_req_last) begin
                        state_n    = SEND;
                        lane_cnt_n = '0;
                    end else begin
                        lane_cnt_n = lane_cnt + 1'b1;
                    end
                end
            end
            SEND: begin
                if (fifo_fire) begin
                    data_n     = '0;
                    strb_n     = '0;
                    lane_cnt_n = '0;
                    state_n    = FILL;
                    if (id_fire) begin
                        data_n[IW-1:0] = id_req_wdata;
                        strb_n[IS-1:0] = id_req_wstrb;
                        if (id_req_last) begin
                            state_n = SEND;
                        end else begin
                            lane_cnt_n = LCW'(1);
                        end
                    end
                end
            end
            default: begin
                state_n    = FILL;
                lane_cnt_n = '0;
            end
        endcase
    end

endmodule
